// File: rtl/vmul_operand_sign_stage.sv
// Registered input stage of the vector multiplier: latches operand pairs and
// decodes per-lane negate masks, with a one-entry skid buffer so in_ready stays registered.
module vmul_operand_sign_stage #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_opcode,
    input  logic [1:0]         in_precision,
    input  logic [WIDTH*4-1:0] in_operand_a,
    input  logic [WIDTH*4-1:0] in_operand_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_opcode,
    output logic [1:0]         out_precision,
    output logic [WIDTH*4-1:0] out_operand_a,
    output logic [WIDTH*4-1:0] out_operand_b,
    output logic [3:0]         out_neg_a,
    output logic [3:0]         out_neg_b,
    output logic [3:0]         out_neg_res
);
    localparam int W4 = WIDTH * 4;

    typedef struct packed {
        logic [1:0]    opcode;
        logic [1:0]    precision;
        logic [W4-1:0] a;
        logic [W4-1:0] b;
        logic [3:0]    neg_a;
        logic [3:0]    neg_b;
        logic [3:0]    neg_res;
    } beat_t;

    // Spread element sign bits across the lanes each element covers.
    function automatic logic [3:0] lane_signs(input logic [3:0] msb, input logic [1:0] prec);
        logic [3:0] m;
        case (prec)
            2'b01:   m = {msb[3], msb[3], msb[1], msb[1]};
            2'b10:   m = {4{msb[3]}};
            default: m = msb;
        endcase
        return m;
    endfunction

    logic [3:0] msb_a, msb_b;
    logic       signed_a, signed_b;
    beat_t      in_beat, out_q, skid_q;
    logic       out_vld_q, skid_full_q;
    logic       accept;

    assign msb_a = {in_operand_a[4*WIDTH-1], in_operand_a[3*WIDTH-1],
                    in_operand_a[2*WIDTH-1], in_operand_a[WIDTH-1]};
    assign msb_b = {in_operand_b[4*WIDTH-1], in_operand_b[3*WIDTH-1],
                    in_operand_b[2*WIDTH-1], in_operand_b[WIDTH-1]};

    // MULH and MULSU treat A as signed; only MULH treats B as signed.
    assign signed_a = in_opcode[0];
    assign signed_b = (in_opcode == 2'b01);

    always_comb begin
        in_beat           = '0;
        in_beat.opcode    = in_opcode;
        in_beat.precision = in_precision;
        in_beat.a         = in_operand_a;
        in_beat.b         = in_operand_b;
        in_beat.neg_a     = {4{signed_a}} & lane_signs(msb_a, in_precision);
        in_beat.neg_b     = {4{signed_b}} & lane_signs(msb_b, in_precision);
        in_beat.neg_res   = in_beat.neg_a ^ in_beat.neg_b;
    end

    assign in_ready = ~skid_full_q & ~rst;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_vld_q   <= 1'b0;
            skid_full_q <= 1'b0;
        end else if (skid_full_q) begin
            // Upstream is stalled while the skid holds a beat.
            if (out_ready) begin
                out_q       <= skid_q;
                skid_full_q <= 1'b0;
            end
        end else if (accept) begin
            if (!out_vld_q || out_ready) begin
                out_q     <= in_beat;
                out_vld_q <= 1'b1;
            end else begin
                skid_q      <= in_beat;
                skid_full_q <= 1'b1;
            end
        end else if (out_ready) begin
            out_vld_q <= 1'b0;
        end
    end

    assign out_valid     = out_vld_q;
    assign out_opcode    = out_q.opcode;
    assign out_precision = out_q.precision;
    assign out_operand_a = out_q.a;
    assign out_operand_b = out_q.b;
    assign out_neg_a     = out_q.neg_a;
    assign out_neg_b     = out_q.neg_b;
    assign out_neg_res   = out_q.neg_res;
endmodule

// File: tb/tb_vmul_operand_sign_stage.sv
// Directed bench for vmul_operand_sign_stage: mask decode, skid backpressure, async reset.
module tb_vmul_operand_sign_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_opcode = '0;
    logic [1:0]  in_precision = '0;
    logic [31:0] in_operand_a = '0;
    logic [31:0] in_operand_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_opcode;
    logic [1:0]  out_precision;
    logic [31:0] out_operand_a;
    logic [31:0] out_operand_b;
    logic [3:0]  out_neg_a;
    logic [3:0]  out_neg_b;
    logic [3:0]  out_neg_res;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vmul_operand_sign_stage #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_precision(in_precision),
        .in_operand_a(in_operand_a), .in_operand_b(in_operand_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_precision(out_precision),
        .out_operand_a(out_operand_a), .out_operand_b(out_operand_b),
        .out_neg_a(out_neg_a), .out_neg_b(out_neg_b), .out_neg_res(out_neg_res)
    );

    task automatic drive(input logic [1:0] op, input logic [1:0] prec,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid     = 1'b1;
        in_opcode    = op;
        in_precision = prec;
        in_operand_a = a;
        in_operand_b = b;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        checks++;
        if ({out_valid, in_ready, out_neg_a, out_neg_b, out_neg_res, out_operand_a, out_operand_b} !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b ready=%b masks=%b/%b/%b a=%h b=%h, expected all zero",
                     out_valid, in_ready, out_neg_a, out_neg_b, out_neg_res, out_operand_a, out_operand_b);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b, expected ready=1 valid=0", in_ready, out_valid);
        end
    endtask

    task automatic test_decode;
        logic [1:0]  op   [7] = '{2'b01, 2'b11, 2'b01, 2'b10, 2'b00, 2'b01, 2'b01};
        logic [1:0]  pr   [7] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00};
        logic [31:0] va   [7] = '{32'h807FFF01, 32'h80007FFF, 32'h80000000, 32'h80000000,
                                  32'h80000000, 32'h00800000, 32'h00800000};
        logic [31:0] vb   [7] = '{32'h01FF01FF, 32'hFFFFFFFF, 32'h00000001, 32'h00000001,
                                  32'h00000001, 32'h00000000, 32'h00000000};
        logic [3:0]  ea   [7] = '{4'b1010, 4'b1100, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
        logic [3:0]  eb   [7] = '{4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0]  er   [7] = '{4'b1111, 4'b1100, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(op[i], pr[i], va[i], vb[i]);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if ({out_valid, out_opcode, out_precision, out_operand_a, out_operand_b} !==
                {1'b1, op[i], pr[i], va[i], vb[i]}) begin
                errors++;
                $display("FAIL decode%0d_beat: valid=%b op=%b prec=%b a=%h b=%h, expected 1 %b %b %h %h",
                         i, out_valid, out_opcode, out_precision, out_operand_a, out_operand_b,
                         op[i], pr[i], va[i], vb[i]);
            end
            checks++;
            if ({out_neg_a, out_neg_b, out_neg_res} !== {ea[i], eb[i], er[i]}) begin
                errors++;
                $display("FAIL decode%0d_masks: a=%b b=%b res=%b, expected %b %b %b",
                         i, out_neg_a, out_neg_b, out_neg_res, ea[i], eb[i], er[i]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL decode_drain: valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        // X: 8-bit MULH, Y: 16-bit MULH (via skid), Z: 32-bit MULSU
        out_ready = 1'b0;
        @(negedge clk);
        drive(2'b01, 2'b00, 32'h11111180, 32'h000000AA);
        @(posedge clk);
        @(negedge clk);
        drive(2'b01, 2'b01, 32'h22228000, 32'h80000000);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_operand_a, out_neg_a} !== {1'b0, 1'b1, 32'h11111180, 4'b0001}) begin
            errors++;
            $display("FAIL bp_hold_x: ready=%b valid=%b a=%h neg_a=%b, expected 0 1 11111180 0001",
                     in_ready, out_valid, out_operand_a, out_neg_a);
        end
        drive(2'b11, 2'b10, 32'h83333333, 32'hFFFFFFFF);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_operand_a} !== {1'b0, 1'b1, 32'h11111180}) begin
            errors++;
            $display("FAIL bp_stall_z: ready=%b valid=%b a=%h, expected 0 1 11111180",
                     in_ready, out_valid, out_operand_a);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_operand_a, out_neg_a, out_neg_b, out_neg_res} !==
            {1'b1, 1'b1, 32'h22228000, 4'b0011, 4'b1100, 4'b1111}) begin
            errors++;
            $display("FAIL bp_emit_y: ready=%b valid=%b a=%h masks=%b/%b/%b, expected 1 1 22228000 0011/1100/1111",
                     in_ready, out_valid, out_operand_a, out_neg_a, out_neg_b, out_neg_res);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_operand_a, out_neg_a, out_neg_b, out_neg_res} !==
            {1'b1, 32'h83333333, 4'b1111, 4'b0000, 4'b1111}) begin
            errors++;
            $display("FAIL bp_emit_z: valid=%b a=%h masks=%b/%b/%b, expected 1 83333333 1111/0000/1111",
                     out_valid, out_operand_a, out_neg_a, out_neg_b, out_neg_res);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_dup: valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_reset_midflight;
        out_ready = 1'b0;
        @(negedge clk);
        drive(2'b01, 2'b00, 32'h80808080, 32'h80808080);
        @(posedge clk);
        @(negedge clk);
        drive(2'b01, 2'b10, 32'hF0000000, 32'h00000000);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b01) begin
            errors++;
            $display("FAIL rst_mid_fill: ready=%b valid=%b, expected 0 1", in_ready, out_valid);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, out_neg_a, out_neg_b, out_neg_res, out_operand_a} !== '0) begin
            errors++;
            $display("FAIL rst_mid_async: valid=%b ready=%b masks=%b/%b/%b a=%h, expected all zero",
                     out_valid, in_ready, out_neg_a, out_neg_b, out_neg_res, out_operand_a);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL rst_mid_release: ready=%b valid=%b, expected 1 0 (skid beat must be gone)",
                     in_ready, out_valid);
        end
        drive(2'b11, 2'b01, 32'h00008000, 32'h00008000);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_operand_a, out_neg_a, out_neg_b, out_neg_res} !==
            {1'b1, 32'h00008000, 4'b0011, 4'b0000, 4'b0011}) begin
            errors++;
            $display("FAIL rst_mid_accept: valid=%b a=%h masks=%b/%b/%b, expected 1 00008000 0011/0000/0011",
                     out_valid, out_operand_a, out_neg_a, out_neg_b, out_neg_res);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_drain: valid=%b, expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vmul_operand_sign_stage.md
Name: vmul_operand_sign_stage

Overview:
- Registered input stage of the vector multiplier. Sits directly upstream of the two's-complement operand stage.
- Accepts packed 32-bit operand pairs with opcode and precision over a valid/ready handshake.
- Decodes per-byte-lane negate masks for operand A, operand B and the result, and forwards everything registered to the two's-complement and lane-select logic.
- A one-entry skid buffer gives full throughput with a registered in_ready.

Parameters:
- WIDTH, 8, lane width in bits. The operand bus is WIDTH*4 bits wide and there is one mask bit per WIDTH-bit lane.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  upstream beat valid
- in_ready  output  1  stage can accept a beat
- in_opcode  input  2  00 MUL, 01 MULH, 10 MULHU, 11 MULSU
- in_precision  input  2  00 8-bit, 01 16-bit, 10 32-bit, 11 treated as 8-bit
- in_operand_a  input  WIDTH*4  packed operand A
- in_operand_b  input  WIDTH*4  packed operand B
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts
- out_opcode  output  2  registered opcode
- out_precision  output  2  registered precision
- out_operand_a  output  WIDTH*4  registered operand A, unmodified
- out_operand_b  output  WIDTH*4  registered operand B, unmodified
- out_neg_a  output  4  per-lane: A element is negative and is treated as signed
- out_neg_b  output  4  per-lane: B element is negative and is treated as signed
- out_neg_res  output  4  out_neg_a XOR out_neg_b

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0; skid empty; all out_* data and mask registers = 0.
  - in_ready=0 while rst is high, 1 in the first cycle after release.
  - Reset mid-transfer drops both the output register and the skid entry. No partial beat survives.
- Signedness per opcode:
  - MUL: A unsigned, B unsigned.
  - MULH: A signed, B signed.
  - MULHU: A unsigned, B unsigned.
  - MULSU: A signed, B unsigned.
- Element sign bit is the MSB of each element:
  - 8-bit (precision 00/11): lane i uses bit WIDTH*(i+1)-1.
  - 16-bit: lanes {1,0} use bit 2*WIDTH-1; lanes {3,2} use bit 4*WIDTH-1.
  - 32-bit: all four lanes use bit 4*WIDTH-1.
- Each mask bit is replicated across every lane of its element. For example, 16-bit with a negative upper element gives mask 1100.
- neg_a = signed_a AND sign_bit. neg_b likewise. neg_res = neg_a XOR neg_b.
- Masks are computed combinationally from the in_* signals and registered with the beat. Latency is 1 cycle from in handshake to out_valid.
- Handshake:
  - A beat transfers when valid and ready are both high in the same cycle.
  - out_* are stable while out_valid=1 and out_ready=0.
  - in_ready = NOT skid_full (registered).
- Output register / skid buffer rules:
  - Accept with the output register empty, or draining this cycle: the beat loads the output register.
  - Accept with out_valid=1 and out_ready=0: the beat loads the skid entry; skid_full=1 next cycle.
  - Skid full and out_ready=1: the skid entry moves to the output register; skid empties; in_ready=1 next cycle.
- Ordering is strictly FIFO and no beat is dropped or duplicated.
- Simultaneous accept and drain with the skid empty: the new beat replaces the output beat; out_valid stays 1.
- Inputs are sampled only on accept. in_* may change freely while in_valid=0 or in_ready=0.

Test Plan:
- 8-bit MULH, A=0x807FFF01, B=0x01FF01FF, out_ready=1 -> next cycle out_valid=1, neg_a=1010, neg_b=0101, neg_res=1111, operands unchanged.
- 16-bit MULSU, A=0x80007FFF, B=0xFFFFFFFF -> neg_a=1100, neg_b=0000, neg_res=1100.
- 32-bit MULH, A=0x80000000, B=0x00000001 -> neg_a=1111, neg_b=0000, neg_res=1111.
- Same operands with MULHU and with MUL -> all masks 0000.
- precision=11, MULH, A=0x00800000, B=0 -> neg_a=0100, identical to the 8-bit result.
- Backpressure: out_ready=0, send beats X,Y,Z back-to-back:
  - X is held on the output and Y goes to the skid.
  - in_ready=0 and Z stalls.
  - Raise out_ready: X, Y, Z emerge in order on consecutive cycles with no loss or duplicates.
- Assert rst with the skid full -> out_valid=0, masks 0 immediately (async). After release, in_ready=1 and the stage accepts on the next cycle.
